// File: rtl/ethernet_mmio_adapter.sv
// Bridges a single-outstanding request/response port onto a word-wide MMIO
// register bus, handling sub-word byte lanes and alignment errors.
module ethernet_mmio_adapter #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 14
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      req_v_i,
  input  logic                      req_write_i,
  input  logic [addr_width_p-1:0]   req_addr_i,
  input  logic [1:0]                req_size_i,
  input  logic [data_width_p-1:0]   req_data_i,
  output logic                      req_ready_o,
  output logic                      resp_v_o,
  output logic                      resp_write_o,
  output logic                      resp_err_o,
  output logic [data_width_p-1:0]   resp_data_o,
  input  logic                      resp_ready_i,
  output logic [addr_width_p-1:0]   addr_o,
  output logic                      write_en_o,
  output logic                      read_en_o,
  output logic [data_width_p/8-1:0] write_mask_o,
  output logic [data_width_p-1:0]   write_data_o,
  input  logic [data_width_p-1:0]   read_data_i
);
  localparam int bytes_lp = data_width_p / 8;
  localparam int off_w_lp = $clog2(bytes_lp);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;
  state_e state, state_next;

  logic                    write_reg;
  logic [addr_width_p-1:0] addr_reg;
  logic [1:0]              size_reg;
  logic [data_width_p-1:0] data_reg;
  logic [data_width_p-1:0] resp_data_reg;
  logic                    err_reg;

  logic       accept;
  logic [3:0] req_span;
  logic [2:0] req_low_mask;
  logic       req_err;

  assign accept       = req_v_i & reset_n_i & (state == IDLE);
  assign req_span     = 4'd1 << req_size_i;
  assign req_low_mask = 3'(req_span - 4'd1);
  assign req_err      = (|(req_addr_i[2:0] & req_low_mask)) || (req_span > 4'(bytes_lp));

  logic [off_w_lp-1:0]     off;
  logic [3:0]              span;
  logic [data_width_p-1:0] shifted;
  logic [data_width_p-1:0] repl_data;
  logic [data_width_p-1:0] read_lanes;
  logic [bytes_lp-1:0]     lane_mask;
  logic [addr_width_p-1:0] aligned_addr;

  assign off          = addr_reg[off_w_lp-1:0];
  assign span         = 4'd1 << size_reg;
  assign shifted      = read_data_i >> {off, 3'b000};
  assign aligned_addr = {addr_reg[addr_width_p-1:off_w_lp], {off_w_lp{1'b0}}};

  // Each byte lane sources from the request word modulo its size, so
  // sub-word writes appear replicated across the whole bus.
  for (genvar gi = 0; gi < bytes_lp; gi++) begin : g_lane
    assign repl_data[8*gi +: 8]  = data_reg[8*(gi & (32'(span) - 32'd1)) +: 8];
    assign lane_mask[gi]         = (32'(gi) >= 32'(off)) && (32'(gi) < 32'(off) + 32'(span));
    assign read_lanes[8*gi +: 8] = (32'(gi) < 32'(span)) ? shifted[8*gi +: 8] : 8'h00;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next   = state;
    req_ready_o  = 1'b0;
    resp_v_o     = 1'b0;
    resp_write_o = 1'b0;
    resp_err_o   = 1'b0;
    resp_data_o  = '0;
    addr_o       = '0;
    write_en_o   = 1'b0;
    read_en_o    = 1'b0;
    write_mask_o = '0;
    write_data_o = '0;
    case (state)
      IDLE: begin
        req_ready_o = reset_n_i;
        if (accept) state_next = req_err ? RESP : ISSUE;
      end
      ISSUE: begin
        addr_o = aligned_addr;
        if (write_reg) begin
          write_en_o   = 1'b1;
          write_mask_o = lane_mask;
          write_data_o = repl_data;
          state_next   = RESP;
        end else begin
          read_en_o  = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: state_next = RESP;
      RESP: begin
        resp_v_o     = 1'b1;
        resp_write_o = write_reg;
        resp_err_o   = err_reg;
        resp_data_o  = resp_data_reg;
        if (resp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Response data starts at zero on every accept so writes and errors return 0.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      size_reg      <= '0;
      data_reg      <= '0;
      err_reg       <= 1'b0;
      resp_data_reg <= '0;
    end else begin
      if (accept) begin
        write_reg     <= req_write_i;
        addr_reg      <= req_addr_i;
        size_reg      <= req_size_i;
        data_reg      <= req_data_i;
        err_reg       <= req_err;
        resp_data_reg <= '0;
      end
      if (state == CAPTURE) resp_data_reg <= read_lanes;
    end
  end
endmodule

// File: tb/tb_ethernet_mmio_adapter.sv
// Directed bench for ethernet_mmio_adapter (32-bit data, 14-bit address).
module tb_ethernet_mmio_adapter;
  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        req_v_i, req_write_i, req_ready_o;
  logic [13:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_data_i;
  logic        resp_v_o, resp_write_o, resp_err_o, resp_ready_i;
  logic [31:0] resp_data_o;
  logic [13:0] addr_o;
  logic        write_en_o, read_en_o;
  logic [3:0]  write_mask_o;
  logic [31:0] write_data_o, read_data_i;

  int checks = 0;
  int errors = 0;

  ethernet_mmio_adapter #(.data_width_p(32), .addr_width_p(14)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_size_i(req_size_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .resp_v_o(resp_v_o), .resp_write_o(resp_write_o), .resp_err_o(resp_err_o),
    .resp_data_o(resp_data_o), .resp_ready_i(resp_ready_i),
    .addr_o(addr_o), .write_en_o(write_en_o), .read_en_o(read_en_o),
    .write_mask_o(write_mask_o), .write_data_o(write_data_o), .read_data_i(read_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive_req(input logic w, input logic [13:0] a, input logic [1:0] s,
                           input logic [31:0] d);
    req_v_i     = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_size_i  = s;
    req_data_i  = d;
  endtask

  initial begin
    reset_n_i = 1'b0; req_v_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
    req_size_i = '0; req_data_i = '0; resp_ready_i = 1'b1; read_data_i = 32'h12345678;
    step(); step();
    chk("rst_req_ready", 64'(req_ready_o), 64'(0));
    chk("rst_resp_v", 64'(resp_v_o), 64'(0));
    chk("rst_strobes", 64'({write_en_o, read_en_o}), 64'(0));
    chk("rst_addr", 64'(addr_o), 64'(0));
    chk("rst_mask_data", 64'({write_mask_o, write_data_o}), 64'(0));
    reset_n_i = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready_o), 64'(1));

    // 4B write DEADBEEF @0x10
    @(negedge clk_i);
    drive_req(1'b1, 14'h0010, 2'd2, 32'hDEADBEEF);
    step();
    req_v_i = 1'b0;
    chk("w4_write_en", 64'(write_en_o), 64'(1));
    chk("w4_read_en", 64'(read_en_o), 64'(0));
    chk("w4_addr", 64'(addr_o), 64'h10);
    chk("w4_mask", 64'(write_mask_o), 64'hF);
    chk("w4_data", 64'(write_data_o), 64'hDEADBEEF);
    chk("w4_no_resp_yet", 64'(resp_v_o), 64'(0));
    step();
    chk("w4_resp_v", 64'(resp_v_o), 64'(1));
    chk("w4_resp_err", 64'(resp_err_o), 64'(0));
    chk("w4_resp_write", 64'(resp_write_o), 64'(1));
    chk("w4_resp_data", 64'(resp_data_o), 64'(0));
    chk("w4_strobe_off", 64'(write_en_o), 64'(0));
    step();
    chk("w4_idle_ready", 64'(req_ready_o), 64'(1));
    $display("txn write4 addr=0010 data=deadbeef done");

    // 1B write A5 @0x13
    drive_req(1'b1, 14'h0013, 2'd0, 32'h000000A5);
    step();
    req_v_i = 1'b0;
    chk("w1_mask", 64'(write_mask_o), 64'h8);
    chk("w1_data", 64'(write_data_o), 64'hA5A5A5A5);
    chk("w1_addr", 64'(addr_o), 64'h10);
    step();
    chk("w1_resp_v", 64'(resp_v_o), 64'(1));
    step();
    $display("txn write1 addr=0013 data=a5 done");

    // 2B read @0x102
    drive_req(1'b0, 14'h0102, 2'd1, 32'h0);
    step();
    req_v_i = 1'b0;
    chk("r2_read_en", 64'(read_en_o), 64'(1));
    chk("r2_write_en", 64'(write_en_o), 64'(0));
    chk("r2_addr", 64'(addr_o), 64'h100);
    step();
    chk("r2_capture_no_resp", 64'(resp_v_o), 64'(0));
    chk("r2_capture_no_strobe", 64'(read_en_o), 64'(0));
    step();
    chk("r2_resp_v", 64'(resp_v_o), 64'(1));
    chk("r2_resp_data", 64'(resp_data_o), 64'h1234);
    chk("r2_resp_flags", 64'({resp_err_o, resp_write_o}), 64'(0));
    step();
    $display("txn read2 addr=0102 data=1234 done");

    // 1B read @0x003
    drive_req(1'b0, 14'h0003, 2'd0, 32'h0);
    step(); req_v_i = 1'b0;
    step(); step();
    chk("r1_resp_data", 64'(resp_data_o), 64'h12);
    step();
    $display("txn read1 addr=0003 data=12 done");

    // misaligned 4B read @0x006
    drive_req(1'b0, 14'h0006, 2'd2, 32'h0);
    step();
    req_v_i = 1'b0;
    chk("mis_resp_v", 64'(resp_v_o), 64'(1));
    chk("mis_resp_err", 64'(resp_err_o), 64'(1));
    chk("mis_resp_data", 64'(resp_data_o), 64'(0));
    chk("mis_no_strobe", 64'({write_en_o, read_en_o}), 64'(0));
    step();
    chk("mis_idle", 64'(req_ready_o), 64'(1));
    $display("txn read4 addr=0006 err=1 done");

    // oversize 8B write @0x000
    drive_req(1'b1, 14'h0000, 2'd3, 32'h55);
    step();
    req_v_i = 1'b0;
    chk("big_resp_err", 64'(resp_err_o), 64'(1));
    chk("big_no_strobe", 64'(write_en_o), 64'(0));
    step();
    $display("txn write8 addr=0000 err=1 done");

    // read response backpressure with a pending request
    read_data_i = 32'hCAFEF00D;
    resp_ready_i = 1'b0;
    drive_req(1'b0, 14'h0020, 2'd2, 32'h0);
    step();
    drive_req(1'b1, 14'h0004, 2'd2, 32'h11223344);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_v", 64'(resp_v_o), 64'(1));
      chk("bp_resp_data", 64'(resp_data_o), 64'hCAFEF00D);
      chk("bp_req_ready", 64'(req_ready_o), 64'(0));
      chk("bp_no_strobe", 64'(write_en_o), 64'(0));
      step();
    end
    resp_ready_i = 1'b1;
    step();
    chk("bp_after_hs_ready", 64'(req_ready_o), 64'(1));
    chk("bp_after_hs_resp_v", 64'(resp_v_o), 64'(0));
    chk("bp_after_hs_no_write", 64'(write_en_o), 64'(0));
    step();
    req_v_i = 1'b0;
    chk("bp_next_write_en", 64'(write_en_o), 64'(1));
    chk("bp_next_addr", 64'(addr_o), 64'h4);
    step(); step();
    $display("txn read4 addr=0020 data=cafef00d backpressured, write4 addr=0004 done");

    // reset during CAPTURE
    drive_req(1'b0, 14'h0040, 2'd2, 32'h0);
    step();
    req_v_i = 1'b0;
    step();
    reset_n_i = 1'b0;
    #1;
    chk("abort_resp_v", 64'(resp_v_o), 64'(0));
    chk("abort_strobes", 64'({write_en_o, read_en_o}), 64'(0));
    chk("abort_req_ready", 64'(req_ready_o), 64'(0));
    chk("abort_addr_data", 64'({addr_o, resp_data_o}), 64'(0));
    step();
    chk("abort_hold_resp_v", 64'(resp_v_o), 64'(0));
    reset_n_i = 1'b1;
    #1;
    chk("abort_release_ready", 64'(req_ready_o), 64'(1));
    chk("abort_release_resp_v", 64'(resp_v_o), 64'(0));
    step(); step();
    chk("abort_no_late_resp", 64'(resp_v_o), 64'(0));
    chk("abort_no_late_strobe", 64'({write_en_o, read_en_o}), 64'(0));
    $display("txn read4 addr=0040 aborted by reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
